// File: rtl/serial_link_pkg.sv
// Shared definitions for the serial bit-stream link (receiver and serialiser sides).
package serial_link_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/word_hold_reg.sv
// 1-entry valid/ready holding register; a completed word arriving while full is dropped and flagged.
module word_hold_reg #(
  parameter int Width = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [Width-1:0] i_word,
  input  logic             i_ready,
  output logic [Width-1:0] o_data,
  output logic             o_valid,
  output logic             o_overrun
);

  logic w_handshake;

  // Consumer handshake for the word currently held.
  always_comb begin
    w_handshake = o_valid && i_ready;
  end

  // Load / drain the held word and report dropped completions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_data    <= {Width{1'b0}};
      o_valid   <= 1'b0;
      o_overrun <= 1'b0;
    end else begin
      o_overrun <= i_load && o_valid && !w_handshake;
      if (i_load && (!o_valid || w_handshake)) begin
        o_data  <= i_word;
        o_valid <= 1'b1;
      end else if (w_handshake) begin
        o_valid <= 1'b0;
      end else begin
        o_valid <= o_valid;
      end
    end
  end

endmodule

// File: rtl/serial_word_receiver.sv
// Reassembles Width-bit words from a strobed serial bit stream and hands them to a
// valid/ready consumer through a 1-entry holding register.
module serial_word_receiver
  import serial_link_pkg::*;
#(
  parameter int Width     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ser_valid,
  input  logic             ser_data,
  input  logic             ser_start,
  output logic [Width-1:0] data_out,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             overrun,
  output logic             frame_err
);

  localparam int            CW   = cnt_width(Width);
  localparam logic [CW-1:0] LAST = CW'(Width - 1);

  state_t           r_state;
  logic [CW-1:0]    r_count;
  logic [Width-1:0] r_shift;
  logic             r_frame_err;

  logic             w_take;
  logic             w_restart;
  logic             w_done;
  logic [CW-1:0]    w_idx;
  logic [Width-1:0] w_next;

  // A start strobe always begins a fresh word at bit index 0, whatever the current state.
  always_comb begin
    w_restart = ser_valid && ser_start;
    w_take    = ser_valid && (ser_start || (r_state == ST_SHIFT));
    w_idx     = w_restart ? {CW{1'b0}} : r_count;
    w_done    = w_take && (w_idx == LAST);
    w_next    = r_shift;
    if (w_restart) begin
      w_next = {Width{1'b0}};
      if (MSB_FIRST) begin
        w_next[0] = ser_data;
      end else begin
        w_next[Width-1] = ser_data;
      end
    end else if (MSB_FIRST) begin
      w_next    = r_shift << 1'b1;
      w_next[0] = ser_data;
    end else begin
      w_next          = r_shift >> 1'b1;
      w_next[Width-1] = ser_data;
    end
  end

  // Frame FSM, bit counter and shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_count     <= {CW{1'b0}};
      r_shift     <= {Width{1'b0}};
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= w_restart && (r_state == ST_SHIFT);
      case (r_state)
        ST_IDLE, ST_SHIFT: begin
          if (w_take) begin
            r_shift <= w_next;
            if (w_done) begin
              r_state <= ST_IDLE;
              r_count <= {CW{1'b0}};
            end else begin
              r_state <= ST_SHIFT;
              r_count <= w_idx + CW'(1);
            end
          end else begin
            r_state <= r_state;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_count <= {CW{1'b0}};
        end
      endcase
    end
  end

  word_hold_reg #(
    .Width(Width)
  ) u_hold (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_load   (w_done),
    .i_word   (w_next),
    .i_ready  (data_ready),
    .o_data   (data_out),
    .o_valid  (data_valid),
    .o_overrun(overrun)
  );

  assign frame_err = r_frame_err;

endmodule
